// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the RegisterFile write port: two one-entry slots (ALU, memory),
// age-then-round-robin issue. Define WB_BYPASS_EN to forward pending writes onto data1/data2.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_d,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_d,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_d,
  output logic              rf_wr,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [15:0]       wr_count,
  output logic              idle
);

  localparam logic [ADDR_W-1:0] XZR = {ADDR_W{1'b1}};

  logic              alu_v_r, mem_v_r;
  logic [ADDR_W-1:0] alu_rd_r, mem_rd_r;
  logic [DATA_W-1:0] alu_d_r, mem_d_r;
  logic              alu_older_r, tie_r, last_mem_r;

  logic alu_load_s, mem_load_s, alu_first_s;
  logic gnt_alu_s, gnt_mem_s, alu_stays_s, mem_stays_s;

  assign alu_ready  = ~alu_v_r;
  assign mem_ready  = ~mem_v_r;
  assign idle       = ~alu_v_r & ~mem_v_r & ~rf_wr;
  // XZR writes complete the handshake but never occupy a slot
  assign alu_load_s = alu_valid & ~alu_v_r & (alu_rd != XZR);
  assign mem_load_s = mem_valid & ~mem_v_r & (mem_rd != XZR);
  // Same-edge arrivals have no age winner, so the side not granted last goes first
  assign alu_first_s = tie_r ? last_mem_r : alu_older_r;
  assign alu_stays_s = alu_v_r & ~gnt_alu_s;
  assign mem_stays_s = mem_v_r & ~gnt_mem_s;

  // Grant selection between the two slots
  always_comb begin
    gnt_alu_s = 1'b0;
    gnt_mem_s = 1'b0;
    if (alu_v_r && mem_v_r) begin
      gnt_alu_s = alu_first_s;
      gnt_mem_s = ~alu_first_s;
    end else if (alu_v_r) begin
      gnt_alu_s = 1'b1;
    end else if (mem_v_r) begin
      gnt_mem_s = 1'b1;
    end else begin
      gnt_alu_s = 1'b0;
      gnt_mem_s = 1'b0;
    end
  end

  // Slot fill/free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_v_r  <= 1'b0;
      mem_v_r  <= 1'b0;
      alu_rd_r <= '0;
      mem_rd_r <= '0;
      alu_d_r  <= '0;
      mem_d_r  <= '0;
    end else begin
      if (alu_load_s) begin
        alu_v_r  <= 1'b1;
        alu_rd_r <= alu_rd;
        alu_d_r  <= alu_d;
      end else if (gnt_alu_s) begin
        alu_v_r <= 1'b0;
      end
      if (mem_load_s) begin
        mem_v_r  <= 1'b1;
        mem_rd_r <= mem_rd;
        mem_d_r  <= mem_d;
      end else if (gnt_mem_s) begin
        mem_v_r <= 1'b0;
      end
    end
  end

  // Age, tie and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_older_r <= 1'b0;
      tie_r       <= 1'b0;
      last_mem_r  <= 1'b1;
    end else begin
      if (alu_load_s && mem_load_s) begin
        tie_r <= 1'b1;
      end else if (gnt_alu_s || gnt_mem_s) begin
        tie_r <= 1'b0;
      end
      // A lone arrival is younger than whatever stays in the other slot
      if (alu_load_s && !mem_load_s) begin
        alu_older_r <= ~mem_stays_s;
      end else if (mem_load_s && !alu_load_s) begin
        alu_older_r <= alu_stays_s;
      end
      if (gnt_mem_s) begin
        last_mem_r <= 1'b1;
      end else if (gnt_alu_s) begin
        last_mem_r <= 1'b0;
      end
    end
  end

  // Write-port issue and committed-write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wr    <= 1'b0;
      rf_rd    <= '0;
      rf_d     <= '0;
      wr_count <= 16'd0;
    end else begin
      wr_count <= wr_count + {15'd0, rf_wr};
      if (gnt_alu_s) begin
        rf_wr <= 1'b1;
        rf_rd <= alu_rd_r;
        rf_d  <= alu_d_r;
      end else if (gnt_mem_s) begin
        rf_wr <= 1'b1;
        rf_rd <= mem_rd_r;
        rf_d  <= mem_d_r;
      end else begin
        rf_wr <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic              yng_v_s, old_v_s;
  logic [ADDR_W-1:0] yng_rd_s, old_rd_s;
  logic [DATA_W-1:0] yng_d_s, old_d_s;

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] dflt,
    input logic yv, input logic [ADDR_W-1:0] y_rd, input logic [DATA_W-1:0] yd,
    input logic ov, input logic [ADDR_W-1:0] o_rd, input logic [DATA_W-1:0] od,
    input logic iv, input logic [ADDR_W-1:0] i_rd, input logic [DATA_W-1:0] id);
    if (addr == XZR) return dflt;
    else if (yv && (y_rd == addr)) return yd;
    else if (ov && (o_rd == addr)) return od;
    else if (iv && (i_rd == addr)) return id;
    else return dflt;
  endfunction

  // The slot issued second holds the most recent value
  assign yng_v_s  = alu_first_s ? mem_v_r  : alu_v_r;
  assign yng_rd_s = alu_first_s ? mem_rd_r : alu_rd_r;
  assign yng_d_s  = alu_first_s ? mem_d_r  : alu_d_r;
  assign old_v_s  = alu_first_s ? alu_v_r  : mem_v_r;
  assign old_rd_s = alu_first_s ? alu_rd_r : mem_rd_r;
  assign old_d_s  = alu_first_s ? alu_d_r  : mem_d_r;

  // Read-port forwarding
  always_comb begin
    data1 = fwd_sel(rn, rf_data1, yng_v_s, yng_rd_s, yng_d_s, old_v_s, old_rd_s, old_d_s,
                    rf_wr, rf_rd, rf_d);
    data2 = fwd_sel(rm, rf_data2, yng_v_s, yng_rd_s, yng_d_s, old_v_s, old_rd_s, old_d_s,
                    rf_wr, rf_rd, rf_d);
  end
`else
  logic unused_raddr_s;
  assign unused_raddr_s = ^{rn, rm};
  assign data1 = rf_data1;
  assign data2 = rf_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a timestamp-based reference model (honours WB_BYPASS_EN when defined).
module tb_regfile_wb_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd, rn, rm, rf_rd;
  logic [DW-1:0] alu_d, mem_d, rf_d, rf_data1, rf_data2, data1, data2;
  logic          rf_wr, idle;
  logic [15:0]   wr_count;

  int chk = 0;
  int pass = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_d(alu_d),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_d(mem_d),
    .rf_rd(rf_rd), .rf_d(rf_d), .rf_wr(rf_wr),
    .rn(rn), .rm(rm), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .data1(data1), .data2(data2), .wr_count(wr_count), .idle(idle)
  );

  // Reference model: each pending write carries its arrival cycle; index 0 = ALU, 1 = MEM
  int            cyc;
  logic          m_v [2];
  logic [AW-1:0] m_rdq [2];
  logic [DW-1:0] m_dq [2];
  int            m_t [2];
  logic          m_last_mem;
  logic          m_wr;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_d;
  logic [15:0]   m_cnt;
  int            m_g;

  function automatic int pick(input logic v0, input logic v1, input int t0, input int t1,
                              input logic last_mem);
    if (v0 && v1) begin
      if (t0 < t1) return 0;
      if (t1 < t0) return 1;
      return last_mem ? 0 : 1;
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  assign m_g = pick(m_v[0], m_v[1], m_t[0], m_t[1], m_last_mem);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0;
      m_v[0] <= 1'b0; m_v[1] <= 1'b0;
      m_rdq[0] <= '0; m_rdq[1] <= '0;
      m_dq[0] <= '0;  m_dq[1] <= '0;
      m_t[0] <= 0;    m_t[1] <= 0;
      m_last_mem <= 1'b1;
      m_wr <= 1'b0; m_rd <= '0; m_d <= '0; m_cnt <= 16'd0;
    end else begin
      cyc   <= cyc + 1;
      m_cnt <= m_cnt + 16'(m_wr);
      m_wr  <= (m_g >= 0);
      if (m_g == 0) begin
        m_rd <= m_rdq[0]; m_d <= m_dq[0]; m_v[0] <= 1'b0; m_last_mem <= 1'b0;
      end else if (m_g == 1) begin
        m_rd <= m_rdq[1]; m_d <= m_dq[1]; m_v[1] <= 1'b0; m_last_mem <= 1'b1;
      end
      if (alu_valid && !m_v[0] && alu_rd != 5'd31) begin
        m_v[0] <= 1'b1; m_rdq[0] <= alu_rd; m_dq[0] <= alu_d; m_t[0] <= cyc;
      end
      if (mem_valid && !m_v[1] && mem_rd != 5'd31) begin
        m_v[1] <= 1'b1; m_rdq[1] <= mem_rd; m_dq[1] <= mem_d; m_t[1] <= cyc;
      end
    end
  end

  // Value the datapath should see for read address a, given RegisterFile value rfv
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input logic [DW-1:0] rfv);
`ifdef WB_BYPASS_EN
    logic ma, mm;
    if (a == 5'd31) return rfv;
    ma = m_v[0] && (m_rdq[0] == a);
    mm = m_v[1] && (m_rdq[1] == a);
    if (ma && mm) begin
      if (m_t[0] > m_t[1]) return m_dq[0];
      if (m_t[1] > m_t[0]) return m_dq[1];
      return m_last_mem ? m_dq[1] : m_dq[0];
    end
    if (ma) return m_dq[0];
    if (mm) return m_dq[1];
    if (m_wr && (m_rd == a)) return m_d;
    return rfv;
`else
    if (a == 5'd31) return rfv;
    return rfv;
`endif
  endfunction

  task automatic idle_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; alu_d = '0; mem_d = '0;
    rn = '0; rm = '0; rf_data1 = '0; rf_data2 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    chk++; if (alu_ready !== 1'b1) $display("FAIL reset_alu_ready got=%0h exp=1", alu_ready); else pass++;
    chk++; if (mem_ready !== 1'b1) $display("FAIL reset_mem_ready got=%0h exp=1", mem_ready); else pass++;
    chk++; if (rf_wr !== 1'b0) $display("FAIL reset_rf_wr got=%0h exp=0", rf_wr); else pass++;
    chk++; if (rf_rd !== 5'd0) $display("FAIL reset_rf_rd got=%0h exp=0", rf_rd); else pass++;
    chk++; if (rf_d !== 64'd0) $display("FAIL reset_rf_d got=%0h exp=0", rf_d); else pass++;
    chk++; if (idle !== 1'b1) $display("FAIL reset_idle got=%0h exp=1", idle); else pass++;
    chk++; if (wr_count !== 16'd0) $display("FAIL reset_wr_count got=%0h exp=0", wr_count); else pass++;
  endtask

  task automatic test_single_write();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_d = 64'hD;
    @(negedge clk);
    alu_valid = 1'b0;
    chk++; if (alu_ready !== 1'b0) $display("FAIL single_slot_busy got=%0h exp=0", alu_ready); else pass++;
    chk++; if (rf_wr !== 1'b0) $display("FAIL single_not_yet got=%0h exp=0", rf_wr); else pass++;
    @(negedge clk);
    chk++; if (rf_wr !== 1'b1) $display("FAIL single_rf_wr got=%0h exp=1", rf_wr); else pass++;
    chk++; if (rf_rd !== 5'd3) $display("FAIL single_rf_rd got=%0h exp=3", rf_rd); else pass++;
    chk++; if (rf_d !== 64'hD) $display("FAIL single_rf_d got=%0h exp=d", rf_d); else pass++;
    chk++; if (alu_ready !== 1'b1) $display("FAIL single_slot_freed got=%0h exp=1", alu_ready); else pass++;
    @(negedge clk);
    chk++; if (wr_count !== 16'd1) $display("FAIL single_wr_count got=%0h exp=1", wr_count); else pass++;
    chk++; if (idle !== 1'b1) $display("FAIL single_idle got=%0h exp=1", idle); else pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_d = 64'hA;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_d = 64'hB;
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk++; if ({alu_ready, mem_ready} !== 2'b00) $display("FAIL simul_ready got=%0b exp=00", {alu_ready, mem_ready}); else pass++;
    @(negedge clk);
    chk++; if ({rf_wr, rf_rd, rf_d} !== {1'b1, 5'd1, 64'hA}) $display("FAIL simul_first got=%0h/%0h exp=1/a", rf_rd, rf_d); else pass++;
    @(negedge clk);
    chk++; if ({rf_wr, rf_rd, rf_d} !== {1'b1, 5'd2, 64'hB}) $display("FAIL simul_second got=%0h/%0h exp=2/b", rf_rd, rf_d); else pass++;
    @(negedge clk);
    chk++; if (wr_count !== 16'd2) $display("FAIL simul_wr_count got=%0h exp=2", wr_count); else pass++;
    chk++; if (rf_wr !== 1'b0) $display("FAIL simul_quiet got=%0h exp=0", rf_wr); else pass++;
  endtask

  task automatic test_age_order();
    logic [DW-1:0] want;
    do_reset();
    mem_valid = 1'b1; mem_rd = 5'd5; mem_d = 64'd1;
    @(negedge clk);
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_d = 64'd2;
    @(negedge clk);
    alu_valid = 1'b0;
    rn = 5'd5; rf_data1 = 64'h77;
    #1;
    chk++; if ({rf_wr, rf_rd, rf_d} !== {1'b1, 5'd5, 64'd1}) $display("FAIL age_first got=%0h/%0h exp=5/1", rf_rd, rf_d); else pass++;
`ifdef WB_BYPASS_EN
    want = 64'd2;
`else
    want = 64'h77;
`endif
    chk++; if (data1 !== want) $display("FAIL age_read got=%0h exp=%0h", data1, want); else pass++;
    @(negedge clk);
    chk++; if ({rf_wr, rf_rd, rf_d} !== {1'b1, 5'd5, 64'd2}) $display("FAIL age_second got=%0h/%0h exp=5/2", rf_rd, rf_d); else pass++;
  endtask

  task automatic test_xzr();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd31; alu_d = 64'hFF;
    #1;
    chk++; if (alu_ready !== 1'b1) $display("FAIL xzr_handshake got=%0h exp=1", alu_ready); else pass++;
    @(negedge clk);
    alu_valid = 1'b0;
    rn = 5'd31; rf_data1 = 64'h1234;
    #1;
    chk++; if (alu_ready !== 1'b1) $display("FAIL xzr_slot_empty got=%0h exp=1", alu_ready); else pass++;
    chk++; if (data1 !== 64'h1234) $display("FAIL xzr_read got=%0h exp=1234", data1); else pass++;
    @(negedge clk);
    chk++; if (rf_wr !== 1'b0) $display("FAIL xzr_rf_wr got=%0h exp=0", rf_wr); else pass++;
    @(negedge clk);
    chk++; if (wr_count !== 16'd0) $display("FAIL xzr_wr_count got=%0h exp=0", wr_count); else pass++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_d = 64'h70;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_d = 64'h80;
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk++; if (idle !== 1'b0) $display("FAIL mid_busy got=%0h exp=0", idle); else pass++;
    reset = 1'b1;
    #1;
    chk++; if (idle !== 1'b1) $display("FAIL mid_idle got=%0h exp=1", idle); else pass++;
    chk++; if ({alu_ready, mem_ready} !== 2'b11) $display("FAIL mid_ready got=%0b exp=11", {alu_ready, mem_ready}); else pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk++; if (rf_wr !== 1'b0) $display("FAIL mid_no_write got=%0h exp=0", rf_wr); else pass++;
    @(negedge clk);
    chk++; if (wr_count !== 16'd0) $display("FAIL mid_wr_count got=%0h exp=0", wr_count); else pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      chk++; if (alu_ready !== !m_v[0]) $display("FAIL rnd_alu_ready cyc=%0d got=%0h exp=%0h", i, alu_ready, !m_v[0]); else pass++;
      chk++; if (mem_ready !== !m_v[1]) $display("FAIL rnd_mem_ready cyc=%0d got=%0h exp=%0h", i, mem_ready, !m_v[1]); else pass++;
      chk++; if (rf_wr !== m_wr) $display("FAIL rnd_rf_wr cyc=%0d got=%0h exp=%0h", i, rf_wr, m_wr); else pass++;
      if (m_wr) begin
        chk++; if ({rf_rd, rf_d} !== {m_rd, m_d}) $display("FAIL rnd_issue cyc=%0d got=%0h/%0h exp=%0h/%0h", i, rf_rd, rf_d, m_rd, m_d); else pass++;
      end
      chk++; if (wr_count !== m_cnt) $display("FAIL rnd_wr_count cyc=%0d got=%0h exp=%0h", i, wr_count, m_cnt); else pass++;
      chk++; if (idle !== (!m_v[0] && !m_v[1] && !m_wr)) $display("FAIL rnd_idle cyc=%0d got=%0h", i, idle); else pass++;
      alu_valid = ($urandom_range(0, 9) < 6);
      mem_valid = ($urandom_range(0, 9) < 6);
      alu_rd = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      mem_rd = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      alu_d = {$urandom, $urandom};
      mem_d = {$urandom, $urandom};
      rn = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
      rm = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
      rf_data1 = {$urandom, $urandom};
      rf_data2 = {$urandom, $urandom};
      #1;
      chk++; if (data1 !== exp_read(rn, rf_data1)) $display("FAIL rnd_data1 cyc=%0d got=%0h exp=%0h", i, data1, exp_read(rn, rf_data1)); else pass++;
      chk++; if (data2 !== exp_read(rm, rf_data2)) $display("FAIL rnd_data2 cyc=%0d got=%0h exp=%0h", i, data2, exp_read(rm, rf_data2)); else pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_simultaneous();
    test_age_order();
    test_xzr();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
